// File: rtl/inc_counter_pkg.sv
// Shared definitions for the inc_counter block: FSM state encoding and default width.
`timescale 1ns/1ps
package inc_counter_pkg;

    localparam int DEF_DATAWIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/inc_counter_inc.sv
// INC: combinational +1, modulo 2^DATAWIDTH. Carry-out is intentionally not exposed;
// the counter detects wrap by comparing its operand against all-ones.
`timescale 1ns/1ps
module INC #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a_i,
    output logic [DATAWIDTH-1:0] y_o
);

    assign y_o = a_i + DATAWIDTH'(1);

endmodule

// File: rtl/inc_counter.sv
// inc_counter: loads init/limit on start, counts up on en until count==limit,
// then pulses done for one cycle. All outputs are registered.
`timescale 1ns/1ps
module inc_counter
    import inc_counter_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] init,
    input  logic [DATAWIDTH-1:0] limit,
    input  logic                 en,
    input  logic                 abort,
    output logic [DATAWIDTH-1:0] count,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap
);

    localparam logic [DATAWIDTH-1:0] ALL_ONES = '1;

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] count_q, count_d;
    logic [DATAWIDTH-1:0] lim_q,   lim_d;
    logic                 wrap_q,  wrap_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic [DATAWIDTH-1:0] count_inc;

    INC #(.DATAWIDTH(DATAWIDTH)) u_inc (
        .a_i (count_q),
        .y_o (count_inc)
    );

    // Next-state and registered-output decode; abort beats terminal beats en in RUN.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;
        wrap_d  = wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = init;
                    lim_d   = limit;
                    wrap_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (count_q == lim_q) begin
                    state_d = ST_DONE;
                end else if (en) begin
                    count_d = count_inc;
                    if (count_q == ALL_ONES) wrap_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // busy/done are registered copies of the next state so they line up with it.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            lim_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_inc_counter.sv
// Bench for inc_counter: directed runs push expected done-time results into a
// queue; a monitor pops and compares whenever done is presented.
`timescale 1ns/1ps
module tb_inc_counter;

    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] init = '0;
    logic [DW-1:0] limit = '0;
    logic          en = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] count;
    logic          busy, done, wrap;

    inc_counter #(.DATAWIDTH(DW)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .init(init), .limit(limit),
        .en(en), .abort(abort), .count(count), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string         nm;
        logic [DW-1:0] cnt;
        logic          wrp;
        int            lat;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   edge_cnt = 0;
    int   start_edge = 0;

    always @(posedge Clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no done (count=%0d)", count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, "_count"}, int'(count), int'(e.cnt));
                chk({e.nm, "_wrap"},  int'(wrap),  int'(e.wrp));
                chk({e.nm, "_lat"},   edge_cnt - start_edge, e.lat);
                chk({e.nm, "_busy"},  int'(busy), 0);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One full run: start, count (en steady or toggling), wait for done, then
    // pulse start during DONE and confirm it is ignored.
    task automatic run(input string nm, input logic [DW-1:0] iv, input logic [DW-1:0] lv,
                       input bit toggle, input bit perturb,
                       input logic [DW-1:0] ecnt, input logic ewrap, input int elat);
        exp_t e;
        int   i;
        e.nm = nm; e.cnt = ecnt; e.wrp = ewrap; e.lat = elat;
        init = iv; limit = lv; en = 1'b1; start = 1'b1;
        start_edge = edge_cnt + 1;
        q.push_back(e);
        step();
        start = 1'b0;
        if (perturb) begin
            init = ~iv; limit = ~lv;
        end
        i = 0;
        while (done !== 1'b1 && i < 300) begin
            start = perturb && (i == 2);
            step();
            if (toggle) en = ~en;
            i++;
        end
        start = 1'b0;
        if (done !== 1'b1) chk({nm, "_timeout"}, 0, 1);
        // done is high now; a start in this DONE cycle must not launch a run.
        start = 1'b1; init = 8'd77; limit = 8'd78;
        step();
        start = 1'b0;
        chk({nm, "_post_busy"},  int'(busy),  0);
        chk({nm, "_post_done"},  int'(done),  0);
        chk({nm, "_post_count"}, int'(count), int'(ecnt));
        step();
        chk({nm, "_idle_busy"},  int'(busy),  0);
    endtask

    initial begin
        // 1. Reset held 2 cycles with start asserted.
        Rst = 1'b0; start = 1'b1; init = 8'd55; limit = 8'd60; en = 1'b1;
        step(); step();
        chk("rst_count", int'(count), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_wrap",  int'(wrap),  0);
        start = 1'b0; Rst = 1'b1;
        step();
        chk("idle_busy", int'(busy), 0);

        // 2. 10 -> 15, with mid-run start/init/limit changes ignored.
        run("t2_basic", 8'd10, 8'd15, 1'b0, 1'b1, 8'd15, 1'b0, 6);
        // 3. 250 -> 3 through wrap-around.
        run("t3_wrap", 8'd250, 8'd3, 1'b0, 1'b0, 8'd3, 1'b1, 10);
        // 4. init == limit: no increment.
        run("t4_eq", 8'd5, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1);
        // 5. en toggling 1/0, wrap cleared from the previous wrapping run.
        run("t5_toggle", 8'd0, 8'd9, 1'b1, 1'b0, 8'd9, 1'b0, 18);

        // en ignored in IDLE.
        en = 1'b1;
        step(); step();
        chk("idle_en_count", int'(count), 9);

        // 6a. Abort at count=4.
        init = 8'd0; limit = 8'd20; en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("abort_pre_count", int'(count), 4);
        chk("abort_pre_busy",  int'(busy),  1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy",  int'(busy),  0);
        chk("abort_done",  int'(done),  0);
        chk("abort_count", int'(count), 4);
        step(); step();
        chk("abort_hold_count", int'(count), 4);

        // Abort coinciding with terminal: abort wins, no done.
        init = 8'd7; limit = 8'd7; start = 1'b1;
        step();
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_term_busy",  int'(busy),  0);
        chk("abort_term_count", int'(count), 7);
        step(); step();

        // 6b. Reset mid-run after a wrap.
        init = 8'd254; limit = 8'd10; en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("midrst_pre_count", int'(count), 0);
        chk("midrst_pre_wrap",  int'(wrap),  1);
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_busy",  int'(busy),  0);
        chk("midrst_done",  int'(done),  0);
        chk("midrst_wrap",  int'(wrap),  0);
        repeat (15) step();
        chk("midrst_stay_busy", int'(busy), 0);

        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
